// File: rtl/vram_arbiter_if.sv
// Signal bundle between the VGA timing/writer/RAM side and the VRAM arbiter.
// The arbiter connects through the slave modport.
interface vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic [9:0]        hcnt;
  logic [9:0]        vcnt;
  logic              hsync_in;
  logic              vsync_in;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              video_on;
  logic              hsync_out;
  logic              vsync_out;
  logic              frame_start;

  modport master (
    output hcnt, vcnt, hsync_in, vsync_in, wr_req, wr_addr, wr_data, ram_rdata,
    input  wr_ack, ram_addr, ram_we, ram_wdata, pix_data, video_on,
           hsync_out, vsync_out, frame_start
  );

  modport slave (
    input  hcnt, vcnt, hsync_in, vsync_in, wr_req, wr_addr, wr_data, ram_rdata,
    output wr_ack, ram_addr, ram_we, ram_wdata, pix_data, video_on,
           hsync_out, vsync_out, frame_start
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out owns the RAM during active video, the writer gets blanking slots.
// Define VRAM_ARB_VBLANK_ONLY_EN to restrict writes to vertical blanking (tear-free updates).
//
// state   | meaning
// S_IDLE  | blanking, no grant; ram_addr held
// S_SCAN  | active video, scan read issued
// S_WRITE | writer granted, ram_we and wr_ack asserted
module vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SH       = 2,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8
) (
  input logic            clk,
  input logic            rst,
  vram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE} state_t;

  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

  state_t            state;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] line_base;
  logic              active;
  logic              at_origin;
  logic              wr_slot;
  logic [2:0]        von_sr;
  logic [2:0]        hs_sr;
  logic [2:0]        vs_sr;

  assign active    = (bus.hcnt < H_ACT) && (bus.vcnt < V_ACT);
  assign at_origin = (bus.hcnt == 10'd0) && (bus.vcnt == 10'd0);

  // S_WRITE is exactly the cycle wr_ack is high, so this blocks back-to-back grants
`ifdef VRAM_ARB_VBLANK_ONLY_EN
  assign wr_slot = !active && (state != S_WRITE) && (bus.vcnt >= V_ACT);
`else
  assign wr_slot = !active && (state != S_WRITE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      bus.wr_ack    <= 1'b0;
    end else begin
      bus.ram_we <= 1'b0;
      bus.wr_ack <= 1'b0;
      if (active) begin
        state        <= S_SCAN;
        // frame-start clear wins, so the first read of a frame is address 0
        bus.ram_addr <= at_origin ? '0 : scan_addr;
      end else if (wr_slot && bus.wr_req) begin
        state         <= S_WRITE;
        bus.ram_addr  <= bus.wr_addr;
        bus.ram_wdata <= bus.wr_data;
        bus.ram_we    <= 1'b1;
        bus.wr_ack    <= 1'b1;
      end else begin
        state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_addr <= '0;
      line_base <= '0;
    end else if (at_origin) begin
      scan_addr <= '0;
      line_base <= '0;
    end else if (active) begin
      if (&bus.hcnt[SH-1:0]) scan_addr <= scan_addr + ADDR_W'(1);
    end else if ((bus.hcnt == H_ACT) && (bus.vcnt < V_ACT)) begin
      // replay the stored line until the last replicated screen line, then move on
      if (&bus.vcnt[SH-1:0]) line_base <= scan_addr;
      else                   scan_addr <= line_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      von_sr          <= 3'b000;
      hs_sr           <= 3'b111;
      vs_sr           <= 3'b111;
      bus.pix_data    <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      von_sr          <= {von_sr[1:0], active};
      hs_sr           <= {hs_sr[1:0], bus.hsync_in};
      vs_sr           <= {vs_sr[1:0], bus.vsync_in};
      bus.pix_data    <= von_sr[1] ? bus.ram_rdata : DATA_W'(0);
      bus.frame_start <= at_origin;
    end
  end

  assign bus.video_on  = von_sr[2];
  assign bus.hsync_out = hs_sr[2];
  assign bus.vsync_out = vs_sr[2];
endmodule
